thermometer_ramp_controller: RTL and testbench

- Sequencing controller for a thermometer-coded unit-cell array, for example the current cells of a segmented DAC.
- Accepts a binary target level through a valid/ready command interface.
- Ramps the thermometer output toward the target one cell per STEP_CYCLES clocks, so the analog side never sees large instantaneous code jumps.
- Reports current level, busy status, and a completion pulse.

---
 rtl/thermometer_ramp_controller.sv | 112 +++++++++++
 tb/tb_thermometer_ramp_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/thermometer_ramp_controller.sv
// thermometer_ramp_controller: ramps a thermometer-coded cell array toward a commanded level one cell per STEP_CYCLES clocks
//   clk, rst        : clock, synchronous active-high reset
//   cmd_valid/ready : target command handshake, cmd_level is the requested level (clamped to WIDTH)
//   thermometer     : registered cell enables, bit i set iff i < level
//   level           : current registered level
//   busy            : ramp in progress
//   done            : one-cycle pulse when level reaches the accepted target
//   THERMO_RAMP_RETARGET_EN : when defined, commands are accepted mid-ramp and retarget it
module thermometer_ramp_controller #(
    parameter int WIDTH       = 8,
    parameter int STEP_CYCLES = 4,
    localparam int LW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LW-1:0]    cmd_level,
    output logic [WIDTH-1:0] thermometer,
    output logic [LW-1:0]    level,
    output logic             busy,
    output logic             done
);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] MAX_LEVEL = LW'(WIDTH);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW-1:0]     target_q, target_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]  therm_q, therm_d;
    logic              done_q, done_d;
    logic [LW-1:0]     clamp;
    logic              accept;

`ifdef THERMO_RAMP_RETARGET_EN
    assign cmd_ready = 1'b1;
`else
    assign cmd_ready = (state_q == IDLE);
`endif
    assign accept = cmd_valid & cmd_ready;
    assign clamp  = (cmd_level > MAX_LEVEL) ? MAX_LEVEL : cmd_level;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                target_d = clamp;
                if (clamp == level_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RAMP;
                    timer_d = RELOAD;
                end
            end
        end else begin
`ifdef THERMO_RAMP_RETARGET_EN
            // Timer is left running on retarget so the step cadence is kept.
            if (accept) target_d = clamp;
`endif
            if (target_d == level_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (timer_q == '0) begin
                level_d = (target_d > level_q) ? level_q + LW'(1) : level_q - LW'(1);
                timer_d = RELOAD;
                if (level_d == target_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    // Decode the next level so the thermometer register updates on the same edge as level.
    always_comb begin
        therm_d = '0;
        for (int i = 0; i < WIDTH; i++) therm_d[i] = (level_d > LW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            target_q <= '0;
            timer_q  <= '0;
            therm_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            therm_q  <= therm_d;
            done_q   <= done_d;
        end
    end

    assign thermometer = therm_q;
    assign level       = level_q;
    assign busy        = (state_q == RAMP);
    assign done        = done_q;
endmodule

// File: tb/tb_thermometer_ramp_controller.sv
// tb_thermometer_ramp_controller: directed checks of the ramp controller with WIDTH=8, STEP_CYCLES=4
module tb_thermometer_ramp_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_level = '0;
    logic [7:0] thermometer;
    logic [3:0] level;
    logic       busy;
    logic       done;
    int checks = 0;
    int errors = 0;

`ifdef THERMO_RAMP_RETARGET_EN
    localparam bit RETGT = 1'b1;
`else
    localparam bit RETGT = 1'b0;
`endif

    thermometer_ramp_controller #(.WIDTH(8), .STEP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_level(cmd_level), .thermometer(thermometer), .level(level),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] therm_of(input int l);
        logic [7:0] ones;
        ones = 8'hFF;
        return (l == 0) ? 8'h00 : ones >> (8 - l);
    endfunction

    task automatic check_state(input string tag, input int l, input bit b, input bit d);
        chk({tag, "_level"}, level, l);
        chk({tag, "_therm"}, thermometer, therm_of(l));
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_done"}, done, d);
    endtask

    // Issue a command from level 'from', expect a ramp ending at 'to'.
    task automatic ramp(input string tag, input int from, input int to, input int cmd);
        int n, dir;
        dir = (to > from) ? 1 : -1;
        n = ((to > from) ? to - from : from - to) * 4;
        cmd_valid = 1'b1;
        cmd_level = 4'(cmd);
        tick;
        cmd_valid = 1'b0;
        check_state({tag, "_acc"}, from, 1'b1, 1'b0);
        chk({tag, "_acc_ready"}, cmd_ready, RETGT);
        for (int k = 1; k <= n; k++) begin
            tick;
            check_state(tag, from + dir * (k / 4), k < n, k == n);
        end
        tick;
        check_state({tag, "_after"}, to, 1'b0, 1'b0);
        chk({tag, "_after_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        check_state("reset", 0, 1'b0, 1'b0);
        chk("reset_ready", cmd_ready, 1'b1);

        ramp("up5", 0, 5, 5);
        chk("up5_therm_hand", thermometer, 8'h1F);

        ramp("clamp15", 5, 8, 15);
        chk("clamp_therm_hand", thermometer, 8'hFF);

        ramp("down2", 8, 2, 2);
        chk("down2_therm_hand", thermometer, 8'h03);

        ramp("up3", 2, 3, 3);
        cmd_valid = 1'b1;
        cmd_level = 4'd3;
        tick;
        cmd_valid = 1'b0;
        check_state("same_lvl", 3, 1'b0, 1'b1);
        tick;
        check_state("same_lvl_after", 3, 1'b0, 1'b0);

        // Reset mid-ramp: return to 0, then ramp toward 8 and reset at level 4.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_state("rst0", 0, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_level = 4'd8;
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 16; k++) tick;
        check_state("mid_ramp", 4, 1'b1, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_state("mid_rst", 0, 1'b0, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        tick;
        check_state("mid_rst_after", 0, 1'b0, 1'b0);

        // Ramp 0->7, new command 0 arrives at level 2.
        cmd_valid = 1'b1;
        cmd_level = 4'd7;
        tick;
        cmd_level = 4'd0;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) tick;
        check_state("bp_lvl2", 2, 1'b1, 1'b0);
        cmd_valid = 1'b1;
        chk("bp_ready", cmd_ready, RETGT);
        if (RETGT) begin
            tick;
            cmd_valid = 1'b0;
            for (int k = 2; k <= 8; k++) begin
                tick;
                check_state("rt", (k < 4) ? 2 : (k < 8) ? 1 : 0, k < 8, k == 8);
            end
        end else begin
            for (int k = 9; k <= 28; k++) begin
                tick;
                check_state("bp", 2 + (k - 8) / 4, k < 28, k == 28);
            end
            cmd_valid = 1'b0;
            tick;
            check_state("bp_after", 7, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
